// File: rtl/pktout_rr_arb.sv
// Packet-level round-robin arbiter: four packet sources share one pktout port through a
// one-cycle register stage, with per-port packet, protocol-error and timeout counters.
//
// state    | meaning
// ARB_IDLE | no grant; picks the next eligible source when downstream is ready
// ARB_XFER | one source granted; its beats are forwarded until end-of-packet or timeout
module pktout_rr_arb #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [3:0]     port_en,
  output logic [3:0]     gnt,
  input  logic [3:0]     in_data_wr,
  input  logic [535:0]   in_data,
  input  logic [3:0]     in_valid_wr,
  input  logic [3:0]     in_valid,
  output logic           pktout_data_wr,
  output logic [133:0]   pktout_data,
  output logic           pktout_data_valid_wr,
  output logic           pktout_data_valid,
  input  logic           pktout_ready,
  input  logic [2:0]     cnt_sel,
  input  logic           cnt_clr,
  output logic [31:0]    cnt_rdata
);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  arb_state_t   state, state_nxt;
  logic [3:0]   gnt_nxt;
  logic [1:0]   last, last_nxt;
  logic [15:0]  idle_left, idle_left_nxt;
  logic         to_hit;

  logic [3:0]   elig;
  logic [1:0]   winner;
  logic         win_vld;
  logic [1:0]   gnt_idx;

  logic         g_data_wr;
  logic         g_valid_wr;
  logic         g_valid;
  logic [133:0] g_data;

  logic         err_hit;
  logic [3:0]   pkt_inc;

  logic [31:0]  pkt_cnt [4];
  logic [31:0]  err_cnt;
  logic [31:0]  to_cnt;

  assign elig = req & port_en;

  // Iterating from the farthest offset down lets the nearest eligible port after last win.
  always_comb begin
    winner  = last;
    win_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (elig[last + 2'(k)]) begin
        winner  = last + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  // gnt is zero outside ARB_XFER, so masking by gnt alone selects the forwarded source.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) g_data = in_data[134*i +: 134];
    end
  end

  assign g_data_wr  = |(in_data_wr  & gnt);
  assign g_valid_wr = |(in_valid_wr & gnt);
  assign g_valid    = |(in_valid    & gnt);

  assign err_hit = |((in_data_wr | in_valid_wr) & ~gnt);
  assign pkt_inc = gnt & in_valid_wr & in_valid;

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    last_nxt      = last;
    idle_left_nxt = idle_left;
    to_hit        = 1'b0;
    case (state)
      ARB_IDLE: begin
        gnt_nxt = 4'b0000;
        if (pktout_ready && win_vld) begin
          state_nxt     = ARB_XFER;
          gnt_nxt       = 4'b0001 << winner;
          idle_left_nxt = TIMEOUT - 16'd1;
        end
      end
      ARB_XFER: begin
        if (g_valid_wr) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = 4'b0000;
          last_nxt  = gnt_idx;
        end else if (g_data_wr) begin
          idle_left_nxt = TIMEOUT - 16'd1;
        end else if (idle_left == 16'd0) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = 4'b0000;
          last_nxt  = gnt_idx;
          to_hit    = 1'b1;
        end else begin
          idle_left_nxt = idle_left - 16'd1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt       <= 4'b0000;
      last      <= 2'd3;
      idle_left <= 16'd0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      last      <= last_nxt;
      idle_left <= idle_left_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktout_data_wr       <= 1'b0;
      pktout_data          <= '0;
      pktout_data_valid_wr <= 1'b0;
      pktout_data_valid    <= 1'b0;
    end else begin
      pktout_data_wr       <= g_data_wr;
      pktout_data          <= g_data;
      pktout_data_valid_wr <= g_valid_wr;
      pktout_data_valid    <= g_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
      err_cnt <= '0;
      to_cnt  <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
      err_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pkt_inc[i]) pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
      end
      if (err_hit) err_cnt <= err_cnt + 32'd1;
      if (to_hit)  to_cnt  <= to_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rdata <= '0;
    end else begin
      case (cnt_sel)
        3'd0:    cnt_rdata <= pkt_cnt[0];
        3'd1:    cnt_rdata <= pkt_cnt[1];
        3'd2:    cnt_rdata <= pkt_cnt[2];
        3'd3:    cnt_rdata <= pkt_cnt[3];
        3'd4:    cnt_rdata <= err_cnt;
        3'd5:    cnt_rdata <= to_cnt;
        3'd6:    cnt_rdata <= {(state == ARB_XFER), 25'b0, gnt, last};
        default: cnt_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pktout_rr_arb.sv
// Bench for pktout_rr_arb: directed packets, a scoreboard of expected output beats checked by
// a negedge monitor, plus grant-timing and counter readback checks.
module tb_pktout_rr_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   port_en;
  logic [3:0]   gnt;
  logic [3:0]   in_data_wr;
  logic [535:0] in_data;
  logic [3:0]   in_valid_wr;
  logic [3:0]   in_valid;
  logic         pktout_data_wr;
  logic [133:0] pktout_data;
  logic         pktout_data_valid_wr;
  logic         pktout_data_valid;
  logic         pktout_ready;
  logic [2:0]   cnt_sel;
  logic         cnt_clr;
  logic [31:0]  cnt_rdata;

  pktout_rr_arb #(.TIMEOUT(16'd16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req                  (req),
    .port_en              (port_en),
    .gnt                  (gnt),
    .in_data_wr           (in_data_wr),
    .in_data              (in_data),
    .in_valid_wr          (in_valid_wr),
    .in_valid             (in_valid),
    .pktout_data_wr       (pktout_data_wr),
    .pktout_data          (pktout_data),
    .pktout_data_valid_wr (pktout_data_valid_wr),
    .pktout_data_valid    (pktout_data_valid),
    .pktout_ready         (pktout_ready),
    .cnt_sel              (cnt_sel),
    .cnt_clr              (cnt_clr),
    .cnt_rdata            (cnt_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int pkt_id  = 0;

  typedef struct {
    logic [133:0] data;
    logic         vwr;
    logic         v;
    int           at;
  } beat_t;

  beat_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n === 1'b1 && (pktout_data_wr === 1'b1 || pktout_data_valid_wr === 1'b1)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: data 0x%0h at cycle %0d, nothing expected", pktout_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (pktout_data !== e.data || pktout_data_wr !== 1'b1 || pktout_data_valid_wr !== e.vwr ||
            pktout_data_valid !== e.v || cyc != e.at) begin
          n_fail++;
          $display("FAIL beat: got data 0x%0h vwr %0b v %0b cyc %0d, expected data 0x%0h vwr %0b v %0b cyc %0d",
                   pktout_data, pktout_data_valid_wr, pktout_data_valid, cyc, e.data, e.vwr, e.v, e.at);
        end
      end
    end
  end

  task automatic clear_inputs();
    in_data_wr  = '0;
    in_data     = '0;
    in_valid_wr = '0;
    in_valid    = '0;
    cnt_clr     = 1'b0;
  endtask

  task automatic next_gnt(input logic [3:0] expv, input string name);
    @(negedge clk);
    check(name, 32'(gnt), 32'(expv));
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [31:0] expv, input string name);
    @(posedge clk); #1;
    cnt_sel = sel;
    @(negedge clk);
    @(negedge clk);
    check(name, cnt_rdata, expv);
  endtask

  // Source s streams an n-beat packet starting the cycle after gnt was seen; intruder ports
  // drive illegal beats alongside the first nerr beats.
  task automatic send_pkt(input int s, input int n, input logic v, input logic [3:0] intr,
                          input int nerr, input logic clr_tail, input string name);
    logic [133:0] bt;
    beat_t e;
    pkt_id++;
    for (int b = 0; b < n; b++) begin
      @(posedge clk); #1;
      clear_inputs();
      bt[133:132] = (b == 0) ? 2'b01 : ((b == n - 1) ? 2'b10 : 2'b11);
      bt[131:0]   = {4'(s), 64'(pkt_id), 64'(b)};
      in_data[134*s +: 134] = bt;
      in_data_wr[s] = 1'b1;
      if (b == n - 1) begin
        in_valid_wr[s] = 1'b1;
        in_valid[s]    = v;
        cnt_clr        = clr_tail;
      end
      if (b < nerr) begin
        for (int i = 0; i < 4; i++) begin
          if (intr[i]) begin
            in_data_wr[i] = 1'b1;
            in_data[134*i +: 134] = {2'b11, 4'(i), 64'hdead_beef, 64'(b)};
          end
        end
      end
      e.data = bt;
      e.vwr  = (b == n - 1);
      e.v    = (b == n - 1) ? v : 1'b0;
      e.at   = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check({name, "_gnt_release"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] sweep_exp [8];

  initial begin
    rst_n        = 1'b0;
    req          = '0;
    port_en      = 4'hf;
    pktout_ready = 1'b1;
    cnt_sel      = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_data_wr", 32'(pktout_data_wr), 32'd0);
    check("reset_rdata", cnt_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_cnt(3'd6, 32'h0000_0003, "reset_status");

    // Port 0 alone, 4-beat packet
    @(posedge clk); #1;
    req = 4'b0001;
    next_gnt(4'b0000, "t1_gnt_same_cycle");
    next_gnt(4'b0001, "t1_gnt");
    req = 4'b0000;
    send_pkt(0, 4, 1'b1, 4'b0000, 0, 1'b0, "t1");
    read_cnt(3'd0, 32'd1, "t1_pkt0");
    read_cnt(3'd6, 32'h0000_0000, "t1_status");

    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    read_cnt(3'd0, 32'd0, "clr_pkt0");

    // Fairness: last=0, so order is 1,2,3,0,1,2,3,0
    @(posedge clk); #1;
    req = 4'hf;
    next_gnt(4'b0000, "fair_gnt_latency");
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (1 + k) % 4;
      next_gnt(4'(1 << p), $sformatf("fair_gnt%0d", k));
      send_pkt(p, 2, 1'b1, 4'b0000, 0, 1'b0, $sformatf("fair%0d", k));
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) read_cnt(3'(i), 32'd2, $sformatf("fair_pkt%0d", i));

    // Mask 0101: ports 2,0,2,0
    @(posedge clk); #1;
    port_en = 4'b0101;
    req     = 4'hf;
    next_gnt(4'b0000, "mask_gnt_latency");
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (k % 2 == 0) ? 2 : 0;
      next_gnt(4'(1 << p), $sformatf("mask_gnt%0d", k));
      send_pkt(p, 2, 1'b1, 4'b0000, 0, 1'b0, $sformatf("mask%0d", k));
    end
    req     = 4'b0000;
    port_en = 4'hf;

    // Flow control: no grant while not ready; ready drop mid-packet does not stall
    @(posedge clk); #1;
    pktout_ready = 1'b0;
    req          = 4'b0010;
    for (int k = 0; k < 4; k++) next_gnt(4'b0000, $sformatf("fc_hold%0d", k));
    @(posedge clk); #1;
    pktout_ready = 1'b1;
    next_gnt(4'b0000, "fc_gnt_latency");
    next_gnt(4'b0010, "fc_gnt");
    req          = 4'b0000;
    pktout_ready = 1'b0;
    send_pkt(1, 3, 1'b1, 4'b0000, 0, 1'b0, "fc");
    pktout_ready = 1'b1;

    // Protocol errors: port 3 intrudes for 2 cycles, port 1 packet discarded
    @(posedge clk); #1;
    req = 4'b0010;
    next_gnt(4'b0000, "err_gnt_latency");
    next_gnt(4'b0010, "err_gnt");
    req = 4'b0000;
    send_pkt(1, 3, 1'b0, 4'b1000, 2, 1'b0, "err");
    @(posedge clk); #1;
    in_valid_wr[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_wr = '0;
    read_cnt(3'd4, 32'd3, "err_cnt");
    read_cnt(3'd1, 32'd3, "err_pkt1");

    // Timeout: port 0 granted and silent; grant held 16 cycles, then port 3 wins
    @(posedge clk); #1;
    req = 4'b0001;
    next_gnt(4'b0000, "to_gnt_latency");
    next_gnt(4'b0001, "to_gnt");
    req = 4'b1001;
    repeat (14) @(negedge clk);
    next_gnt(4'b0001, "to_hold");
    next_gnt(4'b0000, "to_drop");
    next_gnt(4'b1000, "to_next");
    req = 4'b0000;
    send_pkt(3, 2, 1'b1, 4'b0000, 0, 1'b0, "to_next");
    read_cnt(3'd5, 32'd1, "to_cnt");

    sweep_exp = '{32'd4, 32'd3, 32'd4, 32'd3, 32'd3, 32'd1, 32'h0000_0003, 32'd0};
    for (int i = 0; i < 8; i++) read_cnt(3'(i), sweep_exp[i], $sformatf("sweep%0d", i));

    // Clear coincident with a counted tail
    @(posedge clk); #1;
    req = 4'b0100;
    next_gnt(4'b0000, "clr_gnt_latency");
    next_gnt(4'b0100, "clr_gnt");
    req = 4'b0000;
    send_pkt(2, 2, 1'b1, 4'b0000, 0, 1'b1, "clr");
    for (int i = 0; i < 6; i++) read_cnt(3'(i), 32'd0, $sformatf("clr_sweep%0d", i));
    read_cnt(3'd6, 32'h0000_0002, "clr_status");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
